uart_tx_fifo: RTL
=================

# uart_tx_fifo

Byte-serial UART transmitter peripheral for the 9x8 processor core. The core's outport strobe pushes bytes into a small FIFO. A baud-rate state machine drains the FIFO onto an asynchronous serial line: start bit, 8 data bits LSB first, optional even parity, then stop bit(s). Status outputs feed core inports so firmware can poll for space and completion.

## Interface
- G_BAUD_DIV, 868, clock cycles per serial bit (≥2); 868 = 100 MHz / 115200
- G_FIFO_LOG2, 4, FIFO depth = 2**G_FIFO_LOG2 bytes (≥1)
- G_NSTOP, 1, stop bits per frame (1 or 2)
- i_clk  input  1  processor clock, all logic rising-edge
- i_rst_n  input  1  reset; asynchronous, active-low
- i_wr  input  1  outport write strobe, one cycle per byte
- i_data  input  8  byte to send, sampled when i_wr=1
- o_uart_tx  output  1  serial line, idle high
- o_full  output  1  FIFO full
- o_busy  output  1  FIFO non-empty or frame in progress
- o_overflow  output  1  sticky: a write was dropped

## Operation
- Reset values:
  - o_uart_tx=1, o_full=0, o_busy=0, o_overflow=0.
  - FIFO pointers are zeroed and the FSM is in IDLE.
- FIFO:
  - Occupancy counter is G_FIFO_LOG2+1 bits; read and write pointers wrap modulo depth.
  - A write is accepted if !o_full, or if a pop occurs in the same cycle.
  - Otherwise the byte is discarded and o_overflow sets; it is cleared only by reset.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: o_uart_tx=1. If FIFO non-empty (registered count), pop into 8-bit shift register, load baud counter with G_BAUD_DIV-1, go to START.
  - START: o_uart_tx=0. When counter reaches 0: reload, bit index=0, go to DATA.
  - DATA: o_uart_tx=shift[0]. On counter 0: shift right, increment index; after index 7 go to PARITY or STOP.
  - PARITY: o_uart_tx = XOR of the byte (even parity). On counter 0 go to STOP.
  - STOP: o_uart_tx=1 for G_NSTOP*G_BAUD_DIV cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- o_uart_tx is driven from a register (glitch-free).
- Baud counter is ceil(log2(G_BAUD_DIV)) bits and counts down.
- o_busy = (state!=IDLE) | (count!=0), registered.
- o_full = (count==depth), registered.

## Timing
- i_wr high in cycle n with FIFO empty and FSM IDLE:
  - count=1 in n+1.
  - Pop occurs at the end of n+1.
  - o_uart_tx falls at the start of cycle n+2.
- Each bit lasts exactly G_BAUD_DIV cycles.
- Frame length is (10 + G_NSTOP - 1) * G_BAUD_DIV cycles, plus G_BAUD_DIV with parity.
- Back-to-back frames: the next start bit begins in the cycle after the last stop-bit cycle.
- o_busy:
  - Rises in n+1.
  - Falls in the cycle after the last stop-bit cycle if no byte is pending.
- A write in the same cycle as an empty-FIFO pop check is not seen by that check; it is popped one cycle later.
- Simultaneous write and pop with the FIFO full: the write is accepted, count is unchanged, o_full stays 1.
- Reset asserted mid-frame:
  - o_uart_tx goes high immediately (asynchronous).
  - FIFO contents are discarded.
  - After deassertion the line stays idle until a new write.

## Configuration
- Macro: SSBCC_UART_TX_PARITY_EN.
- Defined: PARITY state is compiled in; every frame carries an even-parity bit between bit 7 and the stop bit(s).
- Undefined: no PARITY state or logic; DATA goes directly to STOP; frame is 8N1 (or 8N2 with G_NSTOP=2).

## Test plan
All scenarios use G_BAUD_DIV=4, G_FIFO_LOG2=2, G_NSTOP=1.
- Reset release, no writes, 200 cycles -> o_uart_tx=1, o_busy=0, o_full=0 throughout.
- Write 0x55 in cycle n, parity off:
  - From n+2, o_uart_tx runs 0,1,0,1,0,1,0,1,0,1, each value held 4 cycles.
  - o_busy falls at n+42.
- Same write with SSBCC_UART_TX_PARITY_EN: parity bit 0 is inserted before the stop bit; o_busy falls at n+46.
- Write 0xA3, 0x0F, 0xFF on consecutive cycles:
  - Three frames with no idle gap between stop and start.
  - Decoded bytes are 0xA3, 0x0F, 0xFF.
- Write six bytes on consecutive cycles:
  - o_full asserts after the fourth byte is stored (the first is already popped).
  - The sixth byte is dropped and o_overflow=1.
  - Exactly five bytes are transmitted.
- Assert i_rst_n low during bit 3 of a frame with two bytes queued:
  - o_uart_tx=1 immediately.
  - After release, no further frames are sent and all flags read 0.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO; frame = start, 8 data LSB first, [even parity if SSBCC_UART_TX_PARITY_EN], G_NSTOP stop.
// Latency: write in cycle n -> start bit on o_uart_tx from cycle n+2; back-to-back frames have no idle gap.
// Backpressure: none on i_wr; a write into a full FIFO without a same-cycle pop is dropped and sets sticky o_overflow.
module uart_tx_fifo #(
  parameter int G_BAUD_DIV  = 868,
  parameter int G_FIFO_LOG2 = 4,
  parameter int G_NSTOP     = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_uart_tx,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int DEPTH = 1 << G_FIFO_LOG2;
  localparam int BW    = (G_BAUD_DIV > 1) ? $clog2(G_BAUD_DIV) : 1;
  localparam logic [BW-1:0]          BAUD_LAST = BW'(G_BAUD_DIV - 1);
  localparam logic [BW-1:0]          BAUD_ONE  = BW'(1);
  localparam logic [G_FIFO_LOG2:0]   CNT_FULL  = {1'b1, {G_FIFO_LOG2{1'b0}}};
  localparam logic [G_FIFO_LOG2:0]   CNT_ONE   = (G_FIFO_LOG2 + 1)'(1);
  localparam logic [G_FIFO_LOG2-1:0] PTR_ONE   = G_FIFO_LOG2'(1);
  localparam logic [2:0]             STOP_LAST = 3'(G_NSTOP - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef SSBCC_UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } state_t;

  logic [7:0]             mem [DEPTH];
  logic [G_FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [G_FIFO_LOG2:0]   count, count_nxt;
  logic                   wr_ok, pop;

  state_t        state, state_nxt;
  logic [BW-1:0] baud_cnt, baud_nxt;
  logic [2:0]    bit_idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          baud_done;
`ifdef SSBCC_UART_TX_PARITY_EN
  logic          par_q, par_nxt;
`endif

  // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
  assign wr_ok     = i_wr & (~o_full | pop);
  assign baud_done = (baud_cnt == '0);

  always_comb begin
    count_nxt = count;
    if (wr_ok && !pop)
      count_nxt = count + CNT_ONE;
    else if (!wr_ok && pop)
      count_nxt = count - CNT_ONE;
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          baud_nxt  = BAUD_LAST;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_nxt  = BAUD_LAST;
          idx_nxt   = 3'd0;
          state_nxt = S_DATA;
        end else begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_nxt  = BAUD_LAST;
          shift_nxt = {1'b0, shift[7:1]};
          idx_nxt   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            idx_nxt = 3'd0;
`ifdef SSBCC_UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end else begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end
      end
`ifdef SSBCC_UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_done) begin
          baud_nxt  = BAUD_LAST;
          idx_nxt   = 3'd0;
          state_nxt = S_STOP;
        end else begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end
      end
`endif
      S_STOP: begin
        if (baud_done) begin
          baud_nxt = BAUD_LAST;
          if (bit_idx == STOP_LAST) begin
            idx_nxt = 3'd0;
            // Chain straight into the next start bit when a byte is waiting.
            if (count != '0) begin
              pop       = 1'b1;
              shift_nxt = mem[rd_ptr];
              state_nxt = S_START;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          baud_nxt = baud_cnt - BAUD_ONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

`ifdef SSBCC_UART_TX_PARITY_EN
    par_nxt = pop ? ^mem[rd_ptr] : par_q;
`endif

    // Line level is computed for the upcoming state so the output flop changes with it.
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
`ifdef SSBCC_UART_TX_PARITY_EN
      S_PARITY: tx_nxt = par_nxt;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok)
      mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_full     <= 1'b0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      o_uart_tx  <= 1'b1;
`ifdef SSBCC_UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count      <= count_nxt;
      o_full     <= (count_nxt == CNT_FULL);
      o_busy     <= (state_nxt != S_IDLE) | (count_nxt != '0);
      o_overflow <= o_overflow | (i_wr & ~wr_ok);
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_idx    <= idx_nxt;
      shift      <= shift_nxt;
      o_uart_tx  <= tx_nxt;
`ifdef SSBCC_UART_TX_PARITY_EN
      par_q      <= par_nxt;
`endif
    end
  end

endmodule
